fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display read > screen clear > buffered pixel writes,
// sharing one synchronous single-port RAM.
module fb_arbiter #(
    parameter int FB_DEPTH   = 307200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        disp_en,
    input  logic [18:0] disp_addr,
    output logic [11:0] disp_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [18:0] wr_addr,
    input  logic [11:0] wr_data,
    input  logic        clr_start,
    input  logic [11:0] clr_color,
    output logic        clr_busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata
);

    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [18:0] LAST_ADDR = 19'(FB_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [18:0]   fifo_addr [FIFO_DEPTH];
    logic [11:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [18:0]   clr_cnt, clr_cnt_nxt;
    logic [11:0]   color;
    logic          push, pop, clr_wr, fifo_empty, fifo_full;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign wr_ready   = rstn && (state == IDLE) && !fifo_full;
    assign push       = wr_valid && wr_ready;
    assign clr_busy   = (state == DRAIN) || (state == CLEAR);
    assign disp_data  = mem_rdata;

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        pop         = 1'b0;
        clr_wr      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = disp_addr;
        mem_wdata   = fifo_data[rd_ptr];

        // the display path is combinational, so it must be gated while in reset
        if (rstn && disp_en) begin
            mem_en = 1'b1;
        end else if (rstn && state == CLEAR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = color;
            clr_wr    = 1'b1;
        end else if (rstn && !fifo_empty) begin
            pop      = 1'b1;
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = fifo_addr[rd_ptr];
        end

        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt   = DRAIN;
                    clr_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                if (fifo_empty || (count == (PW+1)'(1) && pop))
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                if (clr_wr) begin
                    if (clr_cnt == LAST_ADDR) begin
                        state_nxt   = IDLE;
                        clr_cnt_nxt = '0;
                    end else begin
                        clr_cnt_nxt = clr_cnt + 19'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            clr_cnt <= '0;
            color   <= 12'h000;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            if (state == IDLE && clr_start)
                color <= clr_color;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage carries no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: vector table for arbitration/FIFO behaviour,
// hand sequences for clear, stall and mid-operation reset.
module tb_fb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        disp_en;
    logic [18:0] disp_addr;
    logic [11:0] disp_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    fb_arbiter #(.FB_DEPTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .disp_en(disp_en), .disp_addr(disp_addr), .disp_data(disp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous single-port RAM model
    logic [11:0] ram [256];
    always @(posedge clk) begin
        if (mem_en && mem_we)
            ram[mem_addr[7:0]] <= mem_wdata;
        else if (mem_en)
            mem_rdata <= ram[mem_addr[7:0]];
    end

    typedef struct {
        logic        d_en;
        logic [18:0] d_addr;
        logic        w_v;
        logic [18:0] w_addr;
        logic [11:0] w_data;
        logic        e_en;
        logic        e_we;
        logic [18:0] e_addr;
        logic [11:0] e_wdata;
        logic        e_ready;
        logic        chk_rd;
        logic [11:0] e_rd;
    } vec_t;

    typedef struct {
        logic [18:0] addr;
        logic [11:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  log_q[$];
    wr_t  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_en   = 1'b0;
        disp_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_start = 1'b0;
        clr_color = '0;
    endtask

    initial begin
        int drop, last_wr;
        for (int i = 0; i < 256; i++) ram[i] = 12'h000;
        ram[100] = 12'hABC;
        ram[5]   = 12'h5A5;
        ram[6]   = 12'h6B6;
        mem_rdata = 12'h000;

        //        d_en d_addr w_v w_addr w_data   e_en e_we e_addr e_wdata e_rdy chk e_rd
        vecs.push_back('{1, 100, 0,  0, 12'h000,  1, 0, 100, 12'h000, 1, 0, 12'h000});
        vecs.push_back('{0,   0, 1, 10, 12'hF00,  0, 0,   0, 12'h000, 1, 1, 12'hABC});
        vecs.push_back('{0,   0, 1, 11, 12'h0F0,  1, 1,  10, 12'hF00, 1, 0, 12'h000});
        vecs.push_back('{0,   0, 1, 12, 12'h00F,  1, 1,  11, 12'h0F0, 1, 0, 12'h000});
        vecs.push_back('{0,   0, 0,  0, 12'h000,  1, 1,  12, 12'h00F, 1, 0, 12'h000});
        vecs.push_back('{0,   0, 0,  0, 12'h000,  0, 0,   0, 12'h000, 1, 0, 12'h000});
        vecs.push_back('{1,   5, 1, 20, 12'h111,  1, 0,   5, 12'h000, 1, 0, 12'h000});
        vecs.push_back('{1,   5, 1, 21, 12'h222,  1, 0,   5, 12'h000, 1, 1, 12'h5A5});
        vecs.push_back('{1,   6, 1, 22, 12'h333,  1, 0,   6, 12'h000, 1, 1, 12'h5A5});
        vecs.push_back('{1,   6, 1, 23, 12'h444,  1, 0,   6, 12'h000, 1, 1, 12'h6B6});
        vecs.push_back('{1,   6, 1, 24, 12'h555,  1, 0,   6, 12'h000, 0, 1, 12'h6B6});
        vecs.push_back('{0,   0, 1, 24, 12'h555,  1, 1,  20, 12'h111, 0, 0, 12'h000});
        vecs.push_back('{0,   0, 1, 24, 12'h555,  1, 1,  21, 12'h222, 1, 0, 12'h000});
        vecs.push_back('{0,   0, 0,  0, 12'h000,  1, 1,  22, 12'h333, 1, 0, 12'h000});
        vecs.push_back('{0,   0, 0,  0, 12'h000,  1, 1,  23, 12'h444, 1, 0, 12'h000});
        vecs.push_back('{0,   0, 0,  0, 12'h000,  1, 1,  24, 12'h555, 1, 0, 12'h000});
        vecs.push_back('{0,   0, 0,  0, 12'h000,  0, 0,   0, 12'h000, 1, 0, 12'h000});

        // reset: outputs quiet even with requests present
        idle_inputs();
        rstn      = 1'b0;
        disp_en   = 1'b1;
        disp_addr = 19'd100;
        wr_valid  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_clr_busy", clr_busy, 0);
        tick();
        rstn = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rel_wr_ready", wr_ready, 1);

        foreach (vecs[k]) begin
            tick();
            disp_en   = vecs[k].d_en;
            disp_addr = vecs[k].d_addr;
            wr_valid  = vecs[k].w_v;
            wr_addr   = vecs[k].w_addr;
            wr_data   = vecs[k].w_data;
            @(negedge clk);
            chk($sformatf("v%0d_mem_en", k), mem_en, vecs[k].e_en);
            chk($sformatf("v%0d_mem_we", k), mem_we, vecs[k].e_we);
            chk($sformatf("v%0d_wr_ready", k), wr_ready, vecs[k].e_ready);
            if (vecs[k].e_en)
                chk($sformatf("v%0d_mem_addr", k), mem_addr, vecs[k].e_addr);
            if (vecs[k].e_we)
                chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].e_wdata);
            if (vecs[k].chk_rd)
                chk($sformatf("v%0d_disp_data", k), disp_data, vecs[k].e_rd);
        end

        // clear with 2 queued writes, display stalls and a second clr_start
        tick();
        idle_inputs();
        disp_en = 1'b1; wr_valid = 1'b1; wr_addr = 19'd30; wr_data = 12'hAAA;
        tick();
        wr_addr = 19'd31; wr_data = 12'hBBB;
        tick();
        wr_valid = 1'b0; clr_start = 1'b1; clr_color = 12'h123;
        drop = -1;
        last_wr = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            disp_en   = (i % 5 == 3);
            disp_addr = 19'd7;
            clr_start = (i == 8);
            clr_color = (i == 8) ? 12'h777 : 12'h123;
            @(negedge clk);
            if (i == 0) begin
                chk("clr_busy_start", clr_busy, 1);
                chk("clr_wr_ready_blocked", wr_ready, 0);
            end
            if (disp_en)
                chk($sformatf("clr_stall_we_%0d", i), mem_we, 0);
            if (mem_en && mem_we) begin
                log_q.push_back('{mem_addr, mem_wdata});
                last_wr = i;
            end
            if (!clr_busy) begin
                drop = i;
                break;
            end
        end
        if (drop < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL clr_timeout: clr_busy still 1 after 100 cycles, required 0");
        end
        chk("clr_busy_drop_cycle", drop, last_wr + 1);
        exp_q.push_back('{19'd30, 12'hAAA});
        exp_q.push_back('{19'd31, 12'hBBB});
        for (int a = 0; a < 16; a++) exp_q.push_back('{19'(a), 12'h123});
        chk("clr_write_count", log_q.size(), exp_q.size());
        foreach (exp_q[j]) begin
            if (j < log_q.size()) begin
                chk($sformatf("clr_wr%0d_addr", j), log_q[j].addr, exp_q[j].addr);
                chk($sformatf("clr_wr%0d_data", j), log_q[j].data, exp_q[j].data);
            end
        end
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_clr_busy_%0d", i), clr_busy, 0);
            chk($sformatf("post_clr_we_%0d", i), mem_we, 0);
            tick();
        end

        // reset during drain discards queued writes
        disp_en = 1'b1; wr_valid = 1'b1; wr_addr = 19'd50; wr_data = 12'hC01;
        tick();
        wr_addr = 19'd51; wr_data = 12'hC02;
        tick();
        wr_valid = 1'b0; clr_start = 1'b1; clr_color = 12'h456;
        tick();
        clr_start = 1'b0;
        @(negedge clk);
        chk("drain_busy", clr_busy, 1);
        tick();
        rstn = 1'b0; disp_en = 1'b0;
        @(negedge clk);
        chk("drain_rst_busy", clr_busy, 0);
        chk("drain_rst_mem_en", mem_en, 0);
        chk("drain_rst_ready", wr_ready, 0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("drain_rel_ready", wr_ready, 1);
        chk("drain_rel_mem_en", mem_en, 0);
        tick();
        @(negedge clk);
        chk("drain_rel_mem_en2", mem_en, 0);

        // reset during clear
        tick();
        clr_start = 1'b1; clr_color = 12'h456;
        tick();
        clr_start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("mid_clr_busy", clr_busy, 1);
        chk("mid_clr_we", mem_we, 1);
        chk("mid_clr_wdata", mem_wdata, 12'h456);
        tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("clr_rst_busy", clr_busy, 0);
        chk("clr_rst_we", mem_we, 0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("clr_rel_ready", wr_ready, 1);
        chk("clr_rel_busy", clr_busy, 0);
        chk("clr_rel_mem_en", mem_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
